// File: rtl/cluster_ctrl_seq_unit.sv
// Cluster control unit with a staggered core-start sequencer.
//
// Holds the end-of-computation flag, per-core fetch enables, per-core boot
// addresses and software event pulses. A start (register write or a rising
// edge on fetch_en_i) runs a sequencer that enables masked cores one at a
// time, with a programmable gap between enables to limit inrush current.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   fetch_en_i          asynchronous external start request
//   req_i .. id_i       peripheral bus request (wen_i=1 is a read)
//   gnt_o, r_*_o        bus grant and response (one cycle after each request)
//   eoc_o               end of computation flag
//   event_o             one-cycle software event pulses
//   seq_done_o          one-cycle pulse when a sequence finishes
//   fetch_enable_o      per-core fetch enable
//   boot_addr_o         per-core boot address, core i at [32*i +: 32]
module cluster_ctrl_seq_unit #(
    parameter int unsigned NB_CORES     = 8,
    parameter int unsigned NB_EVENTS    = 4,
    parameter int unsigned PER_ID_WIDTH = 5,
    parameter logic [31:0] BOOT_ADDR    = 32'h1C000000,
    parameter logic [15:0] STAGGER_RST  = 16'd16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      fetch_en_i,
    input  logic                      req_i,
    input  logic [31:0]               add_i,
    input  logic                      wen_i,
    input  logic [31:0]               wdata_i,
    input  logic [PER_ID_WIDTH-1:0]   id_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [31:0]               r_rdata_o,
    output logic [PER_ID_WIDTH-1:0]   r_id_o,
    output logic                      r_opc_o,
    output logic                      eoc_o,
    output logic [NB_EVENTS-1:0]      event_o,
    output logic                      seq_done_o,
    output logic [NB_CORES-1:0]       fetch_enable_o,
    output logic [NB_CORES*32-1:0]    boot_addr_o
);

    // Wide enough to hold NB_CORES itself (scan end marker).
    localparam int unsigned IdxW = 5;

    typedef enum logic [1:0] {StIdle, StScan, StWait} state_e;

    // Register state
    logic                            eoc_q, eoc_d;
    logic [NB_CORES-1:0]             fetch_en_q, fetch_en_d;
    logic [15:0]                     stagger_q, stagger_d;
    logic [NB_CORES-1:0]             seq_mask_q, seq_mask_d;
    logic                            done_q, done_d;
    logic [NB_EVENTS-1:0]            event_q, event_d;
    logic [NB_CORES-1:0][31:0]       boot_addr_q, boot_addr_d;

    // Bus response
    logic                            r_valid_q, r_valid_d;
    logic [31:0]                     r_rdata_q, r_rdata_d;
    logic [PER_ID_WIDTH-1:0]         r_id_q, r_id_d;

    // Sequencer
    state_e                          state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [15:0]                     cnt_q, cnt_d;
    logic [NB_CORES-1:0]             mask_lat_q, mask_lat_d;
    logic [15:0]                     stag_lat_q, stag_lat_d;
    logic                            seq_done_q, seq_done_d;

    // fetch_en_i synchroniser (two stages) plus edge-detect stage
    logic [2:0]                      sync_q, sync_d;

    logic [5:0]                      reg_idx;
    logic                            wr_en;
    logic                            rd_en;
    logic                            busy;
    logic                            fetch_edge;
    logic [31:0]                     rdata;
    logic                            found;
    logic [IdxW-1:0]                 found_idx;
    logic                            unused_bits;

    assign reg_idx    = add_i[7:2];
    assign wr_en      = req_i & ~wen_i;
    assign rd_en      = req_i & wen_i;
    assign busy       = (state_q != StIdle);
    assign sync_d     = {sync_q[1:0], fetch_en_i};
    assign fetch_edge = sync_q[1] & ~sync_q[2];
    assign unused_bits = ^{add_i[31:8], add_i[1:0], wdata_i};

    // Read mux, sampled in the request cycle.
    always_comb begin
        rdata = '0;
        case (reg_idx)
            6'h00: rdata[0] = eoc_q;
            6'h01, 6'h02, 6'h03: rdata[NB_CORES-1:0] = fetch_en_q;
            6'h04: rdata[15:0] = stagger_q;
            6'h05: rdata[NB_CORES-1:0] = seq_mask_q;
            6'h06: rdata[1:0] = {done_q, busy};
            default: begin
                if (reg_idx[5:4] == 2'b01) begin
                    for (int i = 0; i < NB_CORES; i++) begin
                        if (reg_idx[3:0] == 4'(i)) rdata = boot_addr_q[i];
                    end
                end
            end
        endcase
    end

    // Lowest latched mask bit at or above idx_q.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NB_CORES - 1; i >= 0; i--) begin
            if (mask_lat_q[i] && (IdxW'(i) >= idx_q)) begin
                found     = 1'b1;
                found_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        logic                start_wr;
        logic [NB_CORES-1:0] seq_set;

        eoc_d       = eoc_q;
        fetch_en_d  = fetch_en_q;
        stagger_d   = stagger_q;
        seq_mask_d  = seq_mask_q;
        done_d      = done_q;
        event_d     = '0;
        boot_addr_d = boot_addr_q;
        r_valid_d   = req_i;
        r_rdata_d   = rd_en ? rdata : 32'h0;
        r_id_d      = req_i ? id_i : r_id_q;
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        mask_lat_d  = mask_lat_q;
        stag_lat_d  = stag_lat_q;
        seq_done_d  = 1'b0;
        start_wr    = 1'b0;
        seq_set     = '0;

        if (wr_en) begin
            case (reg_idx)
                6'h00: eoc_d = wdata_i[0];
                6'h01: fetch_en_d = wdata_i[NB_CORES-1:0];
                6'h02: fetch_en_d = fetch_en_q | wdata_i[NB_CORES-1:0];
                6'h03: fetch_en_d = fetch_en_q & ~wdata_i[NB_CORES-1:0];
                6'h04: stagger_d = wdata_i[15:0];
                6'h05: seq_mask_d = wdata_i[NB_CORES-1:0];
                6'h06: begin
                    if (wdata_i[1]) done_d = 1'b0;
                    start_wr = wdata_i[0];
                end
                6'h07: event_d = wdata_i[NB_EVENTS-1:0];
                default: begin
                    if (reg_idx[5:4] == 2'b01) begin
                        for (int i = 0; i < NB_CORES; i++) begin
                            if (reg_idx[3:0] == 4'(i)) boot_addr_d[i] = wdata_i;
                        end
                    end
                end
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (start_wr || fetch_edge) begin
                    state_d    = StScan;
                    idx_d      = '0;
                    // External start ignores SEQ_MASK and brings up every core.
                    mask_lat_d = fetch_edge ? {NB_CORES{1'b1}} : seq_mask_q;
                    stag_lat_d = stagger_q;
                end
            end
            StScan: begin
                if (found) begin
                    for (int i = 0; i < NB_CORES; i++) begin
                        if (found_idx == IdxW'(i)) seq_set[i] = 1'b1;
                    end
                    idx_d = found_idx + IdxW'(1);
                    cnt_d = stag_lat_q;
                    if (stag_lat_q != 16'd0) state_d = StWait;
                end else begin
                    state_d    = StIdle;
                    seq_done_d = 1'b1;
                    done_d     = 1'b1;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) state_d = StScan;
            end
            default: state_d = StIdle;
        endcase

        // Applied after bus updates so the sequencer set wins a same-cycle clear.
        fetch_en_d = fetch_en_d | seq_set;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eoc_q       <= 1'b0;
            fetch_en_q  <= '0;
            stagger_q   <= STAGGER_RST;
            seq_mask_q  <= '0;
            done_q      <= 1'b0;
            event_q     <= '0;
            boot_addr_q <= {NB_CORES{BOOT_ADDR}};
            r_valid_q   <= 1'b0;
            r_rdata_q   <= '0;
            r_id_q      <= '0;
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            mask_lat_q  <= '0;
            stag_lat_q  <= '0;
            seq_done_q  <= 1'b0;
            sync_q      <= '0;
        end else begin
            eoc_q       <= eoc_d;
            fetch_en_q  <= fetch_en_d;
            stagger_q   <= stagger_d;
            seq_mask_q  <= seq_mask_d;
            done_q      <= done_d;
            event_q     <= event_d;
            boot_addr_q <= boot_addr_d;
            r_valid_q   <= r_valid_d;
            r_rdata_q   <= r_rdata_d;
            r_id_q      <= r_id_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            mask_lat_q  <= mask_lat_d;
            stag_lat_q  <= stag_lat_d;
            seq_done_q  <= seq_done_d;
            sync_q      <= sync_d;
        end
    end

    assign gnt_o          = 1'b1;
    assign r_opc_o        = 1'b0;
    assign r_valid_o      = r_valid_q;
    assign r_rdata_o      = r_rdata_q;
    assign r_id_o         = r_id_q;
    assign eoc_o          = eoc_q;
    assign event_o        = event_q;
    assign seq_done_o     = seq_done_q;
    assign fetch_enable_o = fetch_en_q;
    assign boot_addr_o    = boot_addr_q;

endmodule

// File: tb/tb_cluster_ctrl_seq_unit.sv
module tb_cluster_ctrl_seq_unit;

    localparam logic [31:0] Boot = 32'h1C000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [4:0]  id;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic [4:0]  r_id_o;
    logic        r_opc_o;
    logic        eoc_o;
    logic [3:0]  event_o;
    logic        seq_done_o;
    logic [7:0]  fetch_enable_o;
    logic [255:0] boot_addr_o;

    cluster_ctrl_seq_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_en_i     (fetch_en),
        .req_i          (req),
        .add_i          (add),
        .wen_i          (wen),
        .wdata_i        (wdata),
        .id_i           (id),
        .gnt_o          (gnt_o),
        .r_valid_o      (r_valid_o),
        .r_rdata_o      (r_rdata_o),
        .r_id_o         (r_id_o),
        .r_opc_o        (r_opc_o),
        .eoc_o          (eoc_o),
        .event_o        (event_o),
        .seq_done_o     (seq_done_o),
        .fetch_enable_o (fetch_enable_o),
        .boot_addr_o    (boot_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  id;
    } rsp_t;

    rsp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_pulses = 0;

    // Response monitor: pops one expectation per valid response.
    always @(negedge clk) begin
        if (!rst && r_valid_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: r_valid_o=1 rdata=%h id=%0d, required no response",
                         r_rdata_o, r_id_o);
            end else begin
                rsp_t r;
                r = exp_q.pop_front();
                if (r_rdata_o !== r.rdata || r_id_o !== r.id) begin
                    miscompares++;
                    $display("FAIL rsp: rdata=%h id=%0d, required rdata=%h id=%0d",
                             r_rdata_o, r_id_o, r.rdata, r.id);
                end
            end
        end
        if (seq_done_o) done_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request at posedge+1; req stays high so calls can be back-to-back.
    task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic [4:0] rid);
        rsp_t r;
        req   = 1'b1;
        wen   = ~wr;
        add   = a;
        wdata = d;
        id    = rid;
        r.rdata = wr ? 32'h0 : exp_rd;
        r.id    = rid;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        req = 1'b0;
    endtask

    task automatic wait_fe(input logic [7:0] target, input int exp_n, input string name);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 300) begin
            @(negedge clk);
            n++;
            if (fetch_enable_o === target) hit = 1;
        end
        vectors++;
        if (!hit || n != exp_n) begin
            miscompares++;
            $display("FAIL %s: fetch_enable_o=%h after %0d cycles, required %h after %0d cycles",
                     name, fetch_enable_o, n, target, exp_n);
        end
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; req = 1'b0; add = '0; wen = 1'b1; wdata = '0; id = '0;
        tick(2);
        check("rst_fetch_en", 32'(fetch_enable_o), 32'h0);
        check("rst_r_valid", 32'(r_valid_o), 32'h0);
        check("rst_event", 32'(event_o), 32'h0);
        check("rst_seq_done", 32'(seq_done_o), 32'h0);
        check("rst_boot0", boot_addr_o[0 +: 32], Boot);
        check("rst_boot7", boot_addr_o[7*32 +: 32], Boot);
        rst = 1'b0;
        tick(1);

        // Boot address, EOC and unmapped accesses
        bus(1, 32'h4C, 32'h1C008000, 0, 3);
        bus(0, 32'h4C, 0, 32'h1C008000, 7);
        bus(1, 32'h60, 32'hDEADBEEF, 0, 4);
        bus(0, 32'h60, 0, 32'h0, 9);
        bus(0, 32'h40, 0, Boot, 1);
        bus(1, 32'h00, 32'h1, 0, 2);
        bus(0, 32'h00, 0, 32'h1, 5);
        bus_idle();
        check("boot3_out", boot_addr_o[3*32 +: 32], 32'h1C008000);
        check("boot4_out", boot_addr_o[4*32 +: 32], Boot);
        check("eoc_out", 32'(eoc_o), 32'h1);

        // STAGGER=3, mask 0xA5: cores 0,2,5,7 four cycles apart
        bus(1, 32'h10, 32'd3, 0, 0);
        bus(1, 32'h14, 32'hA5, 0, 0);
        bus(1, 32'h18, 32'h1, 0, 0);
        bus_idle();
        wait_fe(8'h01, 2, "seq3_core0");
        wait_fe(8'h05, 4, "seq3_core2");
        wait_fe(8'h25, 4, "seq3_core5");
        wait_fe(8'hA5, 4, "seq3_core7");
        tick(8);
        check("seq3_done_pulses", 32'(done_pulses), 32'd1);
        bus(0, 32'h18, 0, 32'h2, 6);
        bus(1, 32'h18, 32'h2, 0, 6);
        bus(0, 32'h18, 0, 32'h0, 6);

        // FETCH_CLR racing the sequencer set, and start while busy
        bus(1, 32'h0C, 32'hFF, 0, 1);
        bus(1, 32'h18, 32'h1, 0, 2);
        bus(1, 32'h0C, 32'h01, 0, 3);
        bus(1, 32'h18, 32'h1, 0, 4);
        bus_idle();
        check("clr_race_bit0", 32'(fetch_enable_o), 32'h01);
        wait_fe(8'h05, 4, "busy_core2");
        wait_fe(8'h25, 4, "busy_core5");
        wait_fe(8'hA5, 4, "busy_core7");
        tick(8);
        check("busy_done_pulses", 32'(done_pulses), 32'd2);

        // STAGGER=0: one core per cycle
        bus(1, 32'h10, 32'd0, 0, 0);
        bus(1, 32'h0C, 32'hFF, 0, 0);
        bus(1, 32'h14, 32'h0F, 0, 0);
        bus(1, 32'h18, 32'h1, 0, 0);
        bus_idle();
        wait_fe(8'h01, 2, "seq0_core0");
        wait_fe(8'h03, 1, "seq0_core1");
        wait_fe(8'h07, 1, "seq0_core2");
        wait_fe(8'h0F, 1, "seq0_core3");
        tick(4);
        check("seq0_done_pulses", 32'(done_pulses), 32'd3);

        // EVENT pulses
        bus(1, 32'h1C, 32'h5, 0, 0);
        bus_idle();
        @(negedge clk);
        check("event_pulse", 32'(event_o), 32'h5);
        @(negedge clk);
        check("event_clear", 32'(event_o), 32'h0);
        tick(1);
        bus(1, 32'h1C, 32'h3, 0, 0);
        check("event_first", 32'(event_o), 32'h3);
        bus(1, 32'h1C, 32'h8, 0, 0);
        bus_idle();
        @(negedge clk);
        check("event_replace", 32'(event_o), 32'h8);
        @(negedge clk);
        check("event_replace_clear", 32'(event_o), 32'h0);
        tick(1);

        // Reset in the middle of a sequence
        bus(1, 32'h10, 32'd3, 0, 0);
        bus(1, 32'h0C, 32'hFF, 0, 0);
        bus(1, 32'h14, 32'hFF, 0, 0);
        bus(1, 32'h18, 32'h1, 0, 0);
        bus_idle();
        tick(6);
        rst = 1'b1;
        #1;
        check("midrst_fetch_en", 32'(fetch_enable_o), 32'h0);
        check("midrst_eoc", 32'(eoc_o), 32'h0);
        check("midrst_boot3", boot_addr_o[3*32 +: 32], Boot);
        tick(2);
        rst = 1'b0;
        tick(40);
        check("midrst_no_done", 32'(done_pulses), 32'd3);
        bus(0, 32'h10, 0, 32'h10, 11);
        bus(0, 32'h18, 0, 32'h0, 12);
        bus(0, 32'h14, 0, 32'h0, 13);
        bus_idle();

        // External start: all cores, STAGGER_RST+1 apart
        fetch_en = 1'b1;
        wait_fe(8'h01, 5, "ext_core0");
        for (int k = 1; k < 8; k++) begin
            logic [8:0] t;
            t = (9'd1 << (k + 1)) - 9'd1;
            wait_fe(t[7:0], 17, "ext_core");
        end
        tick(20);
        check("ext_done_pulses", 32'(done_pulses), 32'd4);
        fetch_en = 1'b0;
        bus(0, 32'h18, 0, 32'h2, 14);
        bus_idle();
        tick(3);
        check("rsp_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
